// File: rtl/mux_4_pkg.sv
// Select encodings for the 4:1 word mux, shared with any caller that
// drives the select.
package mux_4_pkg;

  localparam logic [1:0] SEL_00 = 2'b00;
  localparam logic [1:0] SEL_01 = 2'b01;
  localparam logic [1:0] SEL_10 = 2'b10;
  localparam logic [1:0] SEL_11 = 2'b11;

endpackage

// File: rtl/mux_4_if.sv
// Data/select bundle for mux_4. The master drives the four data words and
// the select; the slave (the mux) returns the combinational and registered words.
interface mux_4_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] i_d00;
  logic [WIDTH-1:0] i_d01;
  logic [WIDTH-1:0] i_d10;
  logic [WIDTH-1:0] i_d11;
  logic [1:0]       i_s;
  logic [WIDTH-1:0] o_y;
  logic [WIDTH-1:0] o_y_q;

  modport master (
    output i_d00, i_d01, i_d10, i_d11, i_s,
    input  o_y, o_y_q
  );

  modport slave (
    input  i_d00, i_d01, i_d10, i_d11, i_s,
    output o_y, o_y_q
  );

endinterface

// File: rtl/mux_4_mux2.sv
// WIDTH-bit 2:1 mux. An unknown select yields an all-X word instead of a
// bitwise merge of the two inputs.
module mux_4_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4.sv
// 4:1 word mux built as a two-level mux2 tree, with a combinational output
// and a flop-bounded copy that clears asynchronously on reset.
module mux_4
  import mux_4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_rst,
  mux_4_if.slave   bus
);

  logic [WIDTH-1:0] lo_in [2];
  logic [WIDTH-1:0] hi_in [2];
  logic [WIDTH-1:0] pair  [2];
  logic [WIDTH-1:0] y;

  assign lo_in[0] = bus.i_d00;
  assign hi_in[0] = bus.i_d01;
  assign lo_in[1] = bus.i_d10;
  assign hi_in[1] = bus.i_d11;

  // First level: s[0] picks within {d00,d01} and within {d10,d11}.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pair
      mux_4_mux2 #(.WIDTH(WIDTH)) u_pair (
        .a   (lo_in[gi]),
        .b   (hi_in[gi]),
        .sel (bus.i_s[0]),
        .y   (pair[gi])
      );
    end
  endgenerate

  mux_4_mux2 #(.WIDTH(WIDTH)) u_top (
    .a   (pair[0]),
    .b   (pair[1]),
    .sel (bus.i_s[1]),
    .y   (y)
  );

  assign bus.o_y = y;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_y_q <= '0;
    end else begin
      bus.o_y_q <= y;
    end
  end

endmodule

// File: tb/tb_mux_4.sv
// Scoreboard bench for mux_4: a 32-bit instance for the main scenarios and
// an 8-bit instance for the narrow-word check.
module tb_mux_4;
  import mux_4_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  bit   clk_run = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  exp_t e;

  mux_4_if #(.WIDTH(32)) bus32 ();
  mux_4_if #(.WIDTH(8))  bus8 ();

  mux_4 #(.WIDTH(32)) dut32 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus32.slave)
  );

  mux_4 #(.WIDTH(8)) dut8 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus8.slave)
  );

  // Gated so the combinational sweep runs with no clock edges at all.
  always #5 if (clk_run) i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual still running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic test_comb_sweep();
    logic [1:0]  sels [4];
    logic [31:0] exps [4];
    sels = '{SEL_00, SEL_01, SEL_10, SEL_11};
    exps = '{32'h1, 32'h2, 32'h3, 32'h4};
    bus32.i_d00 = 32'h1;
    bus32.i_d01 = 32'h2;
    bus32.i_d10 = 32'h3;
    bus32.i_d11 = 32'h4;
    for (int i = 0; i < 4; i++) begin
      bus32.i_s = sels[i];
      exp_q.push_back('{$sformatf("comb_sweep_s%0d", i), exps[i]});
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (bus32.o_y !== e.exp) begin
        n_fail++;
        $display("FAIL %s: o_y actual %h required %h", e.name, bus32.o_y, e.exp);
      end else
        $display("ok   %s: o_y %h", e.name, bus32.o_y);
    end
  endtask

  task automatic test_data_follow();
    bus32.i_s = SEL_10;
    #1;
    bus32.i_d10 = 32'hDEADBEEF;
    exp_q.push_back('{"data_follow_sel", 32'hDEADBEEF});
    #0;
    #0;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y actual %h required %h", e.name, bus32.o_y, e.exp);
    end else
      $display("ok   %s: o_y %h", e.name, bus32.o_y);
    #1;
    bus32.i_d00 = 32'h11111111;
    bus32.i_d01 = 32'h22222222;
    bus32.i_d11 = 32'h44444444;
    exp_q.push_back('{"data_follow_unsel", 32'hDEADBEEF});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y actual %h required %h", e.name, bus32.o_y, e.exp);
    end else
      $display("ok   %s: o_y %h", e.name, bus32.o_y);
    bus32.i_d00 = 32'h1;
    bus32.i_d01 = 32'h2;
    bus32.i_d10 = 32'h3;
    bus32.i_d11 = 32'h4;
    #1;
  endtask

  task automatic test_reset();
    bus8.i_d00 = 8'hA5;
    bus8.i_d01 = 8'h5A;
    bus8.i_d10 = 8'hFF;
    bus8.i_d11 = 8'h00;
    bus8.i_s   = SEL_10;
    bus32.i_s  = SEL_01;
    i_rst = 1'b1;
    #1;
    exp_q.push_back('{"reset_q32", 32'h0});
    exp_q.push_back('{"reset_q8", 32'h0});
    exp_q.push_back('{"reset_y_follows", 32'h2});
    clk_run = 1'b1;
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y_q !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus32.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus32.o_y_q);
    e = exp_q.pop_front();
    n_checks++;
    if ({24'h0, bus8.o_y_q} !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus8.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus8.o_y_q);
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y actual %h required %h", e.name, bus32.o_y, e.exp);
    end else
      $display("ok   %s: o_y %h", e.name, bus32.o_y);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_registered();
    @(negedge i_clk);
    bus32.i_s = SEL_01;
    exp_q.push_back('{"reg_load_s01", 32'h2});
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y_q !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus32.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus32.o_y_q);
    #2;
    bus32.i_s = SEL_11;
    exp_q.push_back('{"reg_mid_y", 32'h4});
    exp_q.push_back('{"reg_mid_q_hold", 32'h2});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y actual %h required %h", e.name, bus32.o_y, e.exp);
    end else
      $display("ok   %s: o_y %h", e.name, bus32.o_y);
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y_q !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus32.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus32.o_y_q);
    exp_q.push_back('{"reg_next_edge", 32'h4});
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y_q !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus32.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus32.o_y_q);
  endtask

  task automatic test_async_reset();
    #2;
    i_rst = 1'b1;
    exp_q.push_back('{"arst_q_clear", 32'h0});
    exp_q.push_back('{"arst_y_keep", 32'h4});
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y_q !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus32.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus32.o_y_q);
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y actual %h required %h", e.name, bus32.o_y, e.exp);
    end else
      $display("ok   %s: o_y %h", e.name, bus32.o_y);
    exp_q.push_back('{"arst_hold_edge", 32'h0});
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y_q !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus32.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus32.o_y_q);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q.push_back('{"arst_reload", 32'h4});
    @(posedge i_clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus32.o_y_q !== e.exp) begin
      n_fail++;
      $display("FAIL %s: o_y_q actual %h required %h", e.name, bus32.o_y_q, e.exp);
    end else
      $display("ok   %s: o_y_q %h", e.name, bus32.o_y_q);
  endtask

  task automatic test_width8();
    logic [1:0] sels [4];
    logic [7:0] exps [4];
    sels = '{SEL_00, SEL_01, SEL_10, SEL_11};
    exps = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      bus8.i_s = sels[i];
      exp_q.push_back('{$sformatf("w8_y_s%0d", i), {24'h0, exps[i]}});
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({24'h0, bus8.o_y} !== e.exp) begin
        n_fail++;
        $display("FAIL %s: o_y actual %h required %h", e.name, bus8.o_y, e.exp[7:0]);
      end else
        $display("ok   %s: o_y %h", e.name, bus8.o_y);
      exp_q.push_back('{$sformatf("w8_q_s%0d", i), {24'h0, exps[i]}});
      @(posedge i_clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if ({24'h0, bus8.o_y_q} !== e.exp) begin
        n_fail++;
        $display("FAIL %s: o_y_q actual %h required %h", e.name, bus8.o_y_q, e.exp[7:0]);
      end else
        $display("ok   %s: o_y_q %h", e.name, bus8.o_y_q);
    end
  endtask

  initial begin
    bus32.i_d00 = '0;
    bus32.i_d01 = '0;
    bus32.i_d10 = '0;
    bus32.i_d11 = '0;
    bus32.i_s   = SEL_00;
    bus8.i_d00  = '0;
    bus8.i_d01  = '0;
    bus8.i_d10  = '0;
    bus8.i_d11  = '0;
    bus8.i_s    = SEL_00;
    #1;
    test_comb_sweep();
    test_data_follow();
    test_reset();
    test_registered();
    test_async_reset();
    test_width8();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: entries left actual %0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
